// File: rtl/jesd204_pkg.sv
// jesd204_pkg
//   Shared types and constants for the JESD204 subclass-1 SYSREF alignment
//   block: the alignment FSM state encoding and the width of the SYSREF edge
//   counter exposed to the register map.
package jesd204_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ALIGNED = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int SYSREF_CNT_W = 16;

endpackage

// File: rtl/sysref_edge_det.sv
// sysref_edge_det
//   Brings one raw SYSREF input into the coreclk domain through a flop
//   synchroniser and turns its rising edge into a single-cycle pulse. The
//   pulse appears SYNC_STAGES+1 cycles after the input transition and is
//   suppressed while en is low. A level held high yields exactly one pulse.
// Ports
//   coreclk     in   sole clock
//   rst         in   asynchronous reset, active-high
//   din         in   raw SYSREF level
//   en          in   channel enable, gates the pulse
//   edge_pulse  out  registered rising-edge pulse
module sysref_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic coreclk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], din};
      prev       <= sync[SYNC_STAGES-1];
      edge_pulse <= sync[SYNC_STAGES-1] & ~prev & en;
    end
  end

endmodule

// File: rtl/jesd204_sysref_align.sv
// jesd204_sysref_align
//   SYSREF capture and LMFC alignment for multi-device JESD204 subclass-1
//   links. Channel 0 is the master: its SYSREF edge aligns a free-running
//   LMFC counter, repeated on-phase edges build up lock, and off-phase edges
//   raise a sticky phase error (and realign in continuous mode). Every other
//   channel is checked for skew against the same counter without influencing
//   lock.
// Ports
//   coreclk      in   sole clock
//   rst          in   asynchronous reset, active-high
//   sysref_in    in   [NCH]    raw buffered SYSREF per device
//   ch_en        in   [NCH]    per-channel enable
//   lmfc_period  in   [CNT_W]  LMFC length in coreclk cycles (>=2)
//   arm          in   1-cycle pulse, (re)starts alignment
//   continuous   in   1 = realign on any master mismatch, 0 = one-shot
//   lmfc_cnt     out  [CNT_W]  LMFC phase
//   lmfc_tick    out  LMFC boundary while ALIGNED or LOCKED
//   locked       out  alignment locked
//   phase_err    out  sticky master off-phase flag
//   skew_err     out  [NCH]    sticky per-channel skew flags, bit 0 always 0
//   sysref_cnt   out  [16]     saturating master edge count since arm
module jesd204_sysref_align
  import jesd204_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_EDGES  = 4
) (
  input  logic                    coreclk,
  input  logic                    rst,
  input  logic [NCH-1:0]          sysref_in,
  input  logic [NCH-1:0]          ch_en,
  input  logic [CNT_W-1:0]        lmfc_period,
  input  logic                    arm,
  input  logic                    continuous,
  output logic [CNT_W-1:0]        lmfc_cnt,
  output logic                    lmfc_tick,
  output logic                    locked,
  output logic                    phase_err,
  output logic [NCH-1:0]          skew_err,
  output logic [SYSREF_CNT_W-1:0] sysref_cnt
);

  localparam int                GW        = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [GW-1:0]     GOOD_ONE  = 1;
  localparam logic [GW-1:0]     GOOD_LAST = GW'(LOCK_EDGES - 1);

  logic [NCH-1:0]   edges;
  logic [CNT_W-1:0] cnt_last;
  logic             at_last;
  logic             realign;
  state_t           state;
  logic [GW-1:0]    good_cnt;

  function automatic logic [SYSREF_CNT_W-1:0] sat_inc(input logic [SYSREF_CNT_W-1:0] v);
    return (v == '1) ? v : v + SYSREF_CNT_W'(1);
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_det
    sysref_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_det (
      .coreclk   (coreclk),
      .rst       (rst),
      .din       (sysref_in[i]),
      .en        (ch_en[i]),
      .edge_pulse(edges[i])
    );
  end

  // An aligned edge lands on the last count so it coincides with the wrap.
  assign cnt_last  = lmfc_period - CNT_ONE;
  assign at_last   = (lmfc_cnt == cnt_last);
  assign lmfc_tick = (lmfc_cnt == '0) && ((state == ALIGNED) || (state == LOCKED));

  // Master edge that restarts the LMFC; an arm in the same cycle discards it.
  always_comb begin
    realign = 1'b0;
    if (!arm && edges[0]) begin
      case (state)
        ARMED:   realign = 1'b1;
        ALIGNED: realign = !at_last;
        LOCKED:  realign = !at_last && continuous;
        default: realign = 1'b0;
      endcase
    end
  end

  // Free-running LMFC counter; >= keeps it bounded across a live period change.
  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      lmfc_cnt <= '0;
    end else if (realign || (lmfc_cnt >= cnt_last)) begin
      lmfc_cnt <= '0;
    end else begin
      lmfc_cnt <= lmfc_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge coreclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      good_cnt   <= '0;
      locked     <= 1'b0;
      phase_err  <= 1'b0;
      skew_err   <= '0;
      sysref_cnt <= '0;
    end else if (arm) begin
      state      <= ARMED;
      good_cnt   <= '0;
      locked     <= 1'b0;
      phase_err  <= 1'b0;
      skew_err   <= '0;
      sysref_cnt <= '0;
    end else begin
      if (edges[0] && (state != IDLE)) begin
        sysref_cnt <= sat_inc(sysref_cnt);
      end

      case (state)
        ARMED: begin
          if (edges[0]) begin
            state    <= ALIGNED;
            good_cnt <= '0;
          end
        end
        ALIGNED: begin
          if (edges[0]) begin
            if (at_last) begin
              good_cnt <= good_cnt + GOOD_ONE;
              if (good_cnt == GOOD_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              phase_err <= 1'b1;
              good_cnt  <= '0;
            end
          end
        end
        LOCKED: begin
          if (edges[0] && !at_last) begin
            phase_err <= 1'b1;
            if (continuous) begin
              state    <= ALIGNED;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end
        end
        default: ;
      endcase

      // Slaves are judged against the counter value before any realign.
      if ((state == ALIGNED) || (state == LOCKED)) begin
        for (int i = 1; i < NCH; i++) begin
          if (edges[i] && !at_last) begin
            skew_err[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jesd204_sysref_align.sv
module tb_jesd204_sysref_align;

  localparam int NCH   = 2;
  localparam int CNT_W = 10;
  localparam int S     = 2;
  localparam int LOCK  = 4;
  localparam int VW    = CNT_W + 4 + NCH + 16;

  localparam int M_IDLE = 0, M_ARMED = 1, M_ALIGNED = 2, M_LOCKED = 3;

  logic             coreclk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   sysref_in;
  logic [NCH-1:0]   ch_en;
  logic [CNT_W-1:0] lmfc_period;
  logic             arm;
  logic             continuous;
  logic [CNT_W-1:0] lmfc_cnt;
  logic             lmfc_tick;
  logic             locked;
  logic             phase_err;
  logic [NCH-1:0]   skew_err;
  logic [15:0]      sysref_cnt;

  always #5 coreclk = ~coreclk;

  jesd204_sysref_align #(
    .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(S), .LOCK_EDGES(LOCK)
  ) dut (
    .coreclk(coreclk), .rst(rst), .sysref_in(sysref_in), .ch_en(ch_en),
    .lmfc_period(lmfc_period), .arm(arm), .continuous(continuous),
    .lmfc_cnt(lmfc_cnt), .lmfc_tick(lmfc_tick), .locked(locked),
    .phase_err(phase_err), .skew_err(skew_err), .sysref_cnt(sysref_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: LMFC phase is (cycles since reset - last realign) mod period.
  int           pc, anchor, m_state, m_good, m_scnt;
  bit           m_locked, m_perr;
  bit [NCH-1:0] m_skew, m_edge;
  bit [NCH-1:0] hist[$];

  // Pulse plan for directed scenarios.
  int s_off, s_w, s_sh_idx, s_sh_amt;
  bit s_sh_rest;

  // Probe snapshots taken at chosen master edges.
  int           p_cnt[2], p_scnt[2];
  bit           p_lock[2], p_perr[2];

  task automatic model_reset();
    pc = 0; anchor = 0; m_state = M_IDLE; m_good = 0; m_scnt = 0;
    m_locked = 0; m_perr = 0; m_skew = '0; m_edge = '0;
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
  endtask

  function automatic int m_phase();
    return (pc - anchor) % int'(lmfc_period);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    bit tick;
    tick = (m_phase() == 0) && (m_state == M_ALIGNED || m_state == M_LOCKED);
    return {CNT_W'(m_phase()), tick, m_locked, m_perr, m_skew, 16'(m_scnt)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {lmfc_cnt, lmfc_tick, locked, phase_err, skew_err, sysref_cnt};
  endfunction

  // Advance model and DUT by one clock; inputs must already be applied.
  task automatic step();
    int p, c, pre;
    bit good, realign;
    p = int'(lmfc_period);
    c = (pc - anchor) % p;
    good = (c == p - 1);
    realign = 0;
    pre = m_state;
    if (arm) begin
      m_state = M_ARMED; m_good = 0; m_locked = 0; m_perr = 0; m_skew = '0; m_scnt = 0;
    end else begin
      if (m_edge[0] && pre != M_IDLE && m_scnt < 65535) m_scnt++;
      if (m_edge[0]) begin
        if (pre == M_ARMED) begin
          realign = 1; m_state = M_ALIGNED; m_good = 0;
        end else if (pre == M_ALIGNED) begin
          if (good) begin
            m_good++;
            if (m_good == LOCK) begin m_state = M_LOCKED; m_locked = 1; end
          end else begin
            m_perr = 1; realign = 1; m_good = 0;
          end
        end else if (pre == M_LOCKED && !good) begin
          m_perr = 1;
          if (continuous) begin
            realign = 1; m_locked = 0; m_state = M_ALIGNED; m_good = 0;
          end
        end
      end
      if (pre == M_ALIGNED || pre == M_LOCKED)
        for (int i = 1; i < NCH; i++)
          if (m_edge[i] && !good) m_skew[i] = 1;
    end
    pc++;
    if (realign) anchor = pc;
    hist.push_front(sysref_in);
    void'(hist.pop_back());
    m_edge = hist[S] & ~hist[S+1] & ch_en;
    @(posedge coreclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; sysref_in = '0;
    repeat (2) @(posedge coreclk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int rise_at(int j);
    int r;
    r = s_off + 10 * j;
    if (s_sh_idx >= 0 && (j == s_sh_idx || (s_sh_rest && j > s_sh_idx))) r -= s_sh_amt;
    return r;
  endfunction

  function automatic bit pulse_at(int k);
    for (int j = 0; j < 40; j++)
      if (k >= rise_at(j) && k < rise_at(j) + s_w) return 1'b1;
    return 1'b0;
  endfunction

  // Period-10 master pulses from arm; optional early shift, slave delay,
  // extra arm coincident with a master edge, and two probe points.
  task automatic run_seq(input int ncyc, input int sh_idx, input bit sh_rest,
                         input int ch1_dly, input int arm_idx, input int pa,
                         input int pb, output int nbad, output string first);
    s_off = $urandom_range(2, 9); s_w = $urandom_range(1, 4);
    s_sh_idx = sh_idx; s_sh_rest = sh_rest; s_sh_amt = 3;
    nbad = 0; first = "";
    for (int k = 0; k < ncyc; k++) begin
      sysref_in[0] = pulse_at(k);
      sysref_in[1] = pulse_at(k - ch1_dly);
      arm = (k == 0) || (arm_idx >= 0 && k == rise_at(arm_idx) + S + 1);
      step();
      if (k == rise_at(pa) + S + 1) begin
        p_cnt[0] = int'(lmfc_cnt); p_scnt[0] = int'(sysref_cnt); p_lock[0] = locked; p_perr[0] = phase_err;
      end
      if (k == rise_at(pb) + S + 1) begin
        p_cnt[1] = int'(lmfc_cnt); p_scnt[1] = int'(sysref_cnt); p_lock[1] = locked; p_perr[1] = phase_err;
      end
      if (dut_vec() !== exp_vec()) begin
        if (nbad == 0) first = $sformatf("cyc %0d dut %h model %h", k, dut_vec(), exp_vec());
        nbad++;
      end
    end
    arm = 1'b0;
  endtask

  task automatic test_reset();
    lmfc_period = 10; ch_en = '1; continuous = 1'b1;
    do_reset();
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    repeat (3) step();
    n_cmp++;
    if (lmfc_cnt !== 10'd3 || lmfc_tick !== 1'b0) begin
      n_bad++; $display("FAIL idle_count: cnt %0d tick %b want 3/0", lmfc_cnt, lmfc_tick);
    end
  endtask

  task automatic test_align_lock();
    int nb; string fb;
    lmfc_period = 10; ch_en = '1; continuous = 1'b1;
    do_reset();
    run_seq(60, -1, 0, 0, -1, 0, 4, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL align_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (p_cnt[0] !== 0 || p_scnt[0] !== 1 || p_lock[0] !== 1'b0) begin
      n_bad++; $display("FAIL align_first: cnt %0d scnt %0d lock %b want 0/1/0", p_cnt[0], p_scnt[0], p_lock[0]);
    end
    n_cmp++;
    if (p_lock[1] !== 1'b1 || p_scnt[1] !== 5) begin
      n_bad++; $display("FAIL align_lock4: lock %b scnt %0d want 1/5", p_lock[1], p_scnt[1]);
    end
    n_cmp++;
    if (locked !== 1'b1 || phase_err !== 1'b0 || skew_err !== 2'b00) begin
      n_bad++; $display("FAIL align_final: lock %b perr %b skew %b want 1/0/00", locked, phase_err, skew_err);
    end
  endtask

  task automatic test_early_continuous();
    int nb; string fb;
    lmfc_period = 10; ch_en = 2'b01; continuous = 1'b1;
    do_reset();
    run_seq(130, 7, 1, 0, -1, 7, 11, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL early_cont_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (p_cnt[0] !== 0 || p_lock[0] !== 1'b0 || p_perr[0] !== 1'b1) begin
      n_bad++; $display("FAIL early_cont_hit: cnt %0d lock %b perr %b want 0/0/1", p_cnt[0], p_lock[0], p_perr[0]);
    end
    n_cmp++;
    if (p_lock[1] !== 1'b1 || locked !== 1'b1 || phase_err !== 1'b1) begin
      n_bad++; $display("FAIL early_cont_relock: lock %b/%b perr %b want 1/1/1", p_lock[1], locked, phase_err);
    end
  endtask

  task automatic test_early_oneshot();
    int nb; string fb;
    lmfc_period = 10; ch_en = 2'b01; continuous = 1'b0;
    do_reset();
    run_seq(100, 7, 0, 0, -1, 7, 8, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL early_once_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (p_cnt[0] !== 7 || p_lock[0] !== 1'b1 || p_perr[0] !== 1'b1) begin
      n_bad++; $display("FAIL early_once_hit: cnt %0d lock %b perr %b want 7/1/1", p_cnt[0], p_lock[0], p_perr[0]);
    end
    n_cmp++;
    if (p_cnt[1] !== 0 || locked !== 1'b1) begin
      n_bad++; $display("FAIL early_once_after: cnt %0d lock %b want 0/1", p_cnt[1], locked);
    end
  endtask

  task automatic test_skew();
    int nb; string fb;
    lmfc_period = 10; ch_en = 2'b11; continuous = 1'b1;
    do_reset();
    run_seq(60, -1, 0, 1, -1, 0, 4, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL skew_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (skew_err !== 2'b10 || locked !== 1'b1) begin
      n_bad++; $display("FAIL skew_late: skew %b lock %b want 10/1", skew_err, locked);
    end
    ch_en = 2'b01;
    run_seq(60, -1, 0, 1, -1, 0, 4, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL skew_dis_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (skew_err !== 2'b00 || locked !== 1'b1) begin
      n_bad++; $display("FAIL skew_disabled: skew %b lock %b want 00/1", skew_err, locked);
    end
  endtask

  task automatic test_arm_collision();
    int nb; string fb;
    lmfc_period = 10; ch_en = 2'b01; continuous = 1'b1;
    do_reset();
    run_seq(80, 6, 1, 0, 5, 5, 6, nb, fb);
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL arm_edge_trace: %0d bad cycles, first %s", nb, fb); end
    n_cmp++;
    if (p_scnt[0] !== 0 || p_lock[0] !== 1'b0 || p_perr[0] !== 1'b0) begin
      n_bad++; $display("FAIL arm_edge_drop: scnt %0d lock %b perr %b want 0/0/0", p_scnt[0], p_lock[0], p_perr[0]);
    end
    n_cmp++;
    if (p_cnt[1] !== 0 || p_scnt[1] !== 1 || p_perr[1] !== 1'b0) begin
      n_bad++; $display("FAIL arm_edge_next: cnt %0d scnt %0d perr %b want 0/1/0", p_cnt[1], p_scnt[1], p_perr[1]);
    end
  endtask

  task automatic test_reset_midrun();
    int nb, maxc; string fb;
    lmfc_period = 10; ch_en = 2'b11; continuous = 1'b1;
    do_reset();
    run_seq(60, -1, 0, 0, -1, 0, 4, nb, fb);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL pre_reset_lock: lock %b want 1", locked); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin n_bad++; $display("FAIL async_reset: got %h want 0", dut_vec()); end
    sysref_in = '1;
    repeat (2) @(posedge coreclk);
    #1;
    rst = 1'b0;
    model_reset();
    maxc = 0; nb = 0;
    for (int k = 0; k < 40; k++) begin
      arm = (k == 0);
      step();
      if (int'(sysref_cnt) > maxc) maxc = int'(sysref_cnt);
      if (dut_vec() !== exp_vec()) nb++;
    end
    arm = 1'b0;
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL held_high_trace: %0d bad cycles", nb); end
    n_cmp++;
    if (maxc > 1 || sysref_cnt !== 16'd1) begin
      n_bad++; $display("FAIL held_high_count: max %0d final %0d want <=1/1", maxc, sysref_cnt);
    end
    sysref_in = '0;
  endtask

  task automatic test_random();
    int nb, p; string fb;
    p = $urandom_range(3, 15);
    lmfc_period = CNT_W'(p); ch_en = '1; continuous = 1'b1;
    do_reset();
    nb = 0; fb = "";
    for (int k = 0; k < 600; k++) begin
      sysref_in[0] = ((k % p) < 2);
      if ($urandom_range(0, 29) == 0) sysref_in[0] = ~sysref_in[0];
      if ($urandom_range(0, 3) == 0) sysref_in[1] = ~sysref_in[1];
      if ($urandom_range(0, 49) == 0) ch_en = NCH'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      arm = (k == 0) || ($urandom_range(0, 99) == 0);
      step();
      if (dut_vec() !== exp_vec()) begin
        if (nb == 0) fb = $sformatf("cyc %0d dut %h model %h", k, dut_vec(), exp_vec());
        nb++;
      end
    end
    arm = 1'b0;
    n_cmp++;
    if (nb !== 0) begin n_bad++; $display("FAIL random_trace: %0d bad cycles, first %s", nb, fb); end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; continuous = 1'b1; sysref_in = '0; ch_en = '1; lmfc_period = 10;
    test_reset();
    test_align_lock();
    test_early_continuous();
    test_early_oneshot();
    test_skew();
    test_arm_collision();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
